// File: rtl/lib_arbiter_pkg.sv
// rtl/lib_arbiter_pkg.sv - shared state type, default sizes and one-hot helper for the arbiters
package lib_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } col_arb_state_t;

   localparam int ARB_DEF_COLS     = 8;
   localparam int ARB_DEF_COL_ADD  = 3;
   localparam int ARB_DEF_HOLD_MAX = 0;
   localparam int ARB_MAX_W        = 64;

   // Only the low `width` bits of the zero-extended vector are considered.
   function automatic int unsigned onehot_to_bin(input logic [ARB_MAX_W-1:0] oh, input int width);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < ARB_MAX_W; i++) begin
         if (i < width && oh[i]) idx |= unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/Priority_arb.sv
// rtl/Priority_arb.sv - fixed-priority arbiter: grants the lowest-index active request
module Priority_arb #(
   parameter int Lvl_ROWS = 8
) (
   input  logic [Lvl_ROWS-1:0] req_i,
   output logic [Lvl_ROWS-1:0] gnt_o
);

   // Two's-complement trick isolates the least-significant set bit.
   assign gnt_o = req_i & (~req_i + Lvl_ROWS'(1));

endmodule

// File: rtl/column_pass_arbiter.sv
// rtl/column_pass_arbiter.sv - one ascending grant pass per row scan with valid/ack hold and timeout
// COL_ARB_SNAPSHOT_EN: serve only the requests present when the pass starts.
module column_pass_arbiter
   import lib_arbiter_pkg::*;
#(
   parameter int Lvl_COLS    = ARB_DEF_COLS,
   parameter int Lvl_COL_ADD = ARB_DEF_COL_ADD,
   parameter int HOLD_MAX    = ARB_DEF_HOLD_MAX
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic [Lvl_COLS-1:0]    req_i,
   input  logic                   ack_i,
   output logic [Lvl_COLS-1:0]    gnt_o,
   output logic                   gnt_valid_o,
   output logic [Lvl_COL_ADD-1:0] yadd_o,
   output logic                   grp_release_o,
   output logic                   timeout_o,
   output logic                   busy_o
);

   localparam int CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
   localparam logic [Lvl_COLS-1:0] ALL_ONES = '1;

   if (Lvl_COLS < 2 || Lvl_COLS > ARB_MAX_W) begin : g_bad_cols
      $error("column_pass_arbiter: Lvl_COLS out of range");
   end
   if (Lvl_COL_ADD < $clog2(Lvl_COLS)) begin : g_bad_col_add
      $error("column_pass_arbiter: Lvl_COL_ADD too narrow for Lvl_COLS");
   end

   col_arb_state_t         state_q;
   logic [Lvl_COLS-1:0]    mask_q;
   logic [Lvl_COLS-1:0]    gnt_q;
   logic [Lvl_COL_ADD-1:0] yadd_q;
   logic                   valid_q;
   logic                   rel_q;
   logic                   to_q;
   logic [CNT_W-1:0]       hold_q;

   logic [Lvl_COLS-1:0]    cand;
   logic [Lvl_COLS-1:0]    mask_req;
   logic [Lvl_COLS-1:0]    pick;
   logic [Lvl_COLS-1:0]    mask_after;
   logic [Lvl_COL_ADD-1:0] pick_idx;
   logic                   hold_expired;
   logic                   advance;
   logic                   load_grant;

`ifdef COL_ARB_SNAPSHOT_EN
   logic [Lvl_COLS-1:0]    snap_q;
   assign cand = (state_q == IDLE) ? req_i : snap_q;
`else
   assign cand = req_i;
`endif

   assign mask_req = cand & mask_q;

   Priority_arb #(.Lvl_ROWS(Lvl_COLS)) u_prio (
      .req_i (mask_req),
      .gnt_o (pick)
   );

   assign pick_idx     = Lvl_COL_ADD'(onehot_to_bin(ARB_MAX_W'(pick), Lvl_COLS));
   // Everything strictly above the picked column stays eligible this pass.
   assign mask_after   = ~(pick | (pick - Lvl_COLS'(1)));
   assign hold_expired = (HOLD_MAX > 0) && (hold_q == CNT_W'(HOLD_LAST));
   // After a timeout the grant is already gone, so the pass moves on unconditionally.
   assign advance      = !valid_q || ack_i;
   assign load_grant   = (|mask_req) && ((state_q == IDLE) || (state_q == GRANT && advance));

   always_ff @(posedge clk_i) begin
      if (reset_i || !enable_i) begin
         state_q <= IDLE;
         mask_q  <= ALL_ONES;
         gnt_q   <= '0;
         yadd_q  <= '0;
         valid_q <= 1'b0;
         rel_q   <= 1'b0;
         to_q    <= 1'b0;
         hold_q  <= '0;
`ifdef COL_ARB_SNAPSHOT_EN
         snap_q  <= '0;
`endif
      end else begin
         rel_q <= 1'b0;
         to_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|mask_req) state_q <= GRANT;
            end
            GRANT: begin
               if (valid_q && !ack_i) begin
                  if (hold_expired) begin
                     gnt_q   <= '0;
                     yadd_q  <= '0;
                     valid_q <= 1'b0;
                     to_q    <= 1'b1;
                  end else begin
                     hold_q <= hold_q + CNT_W'(1);
                  end
               end else if (!(|mask_req)) begin
                  gnt_q   <= '0;
                  yadd_q  <= '0;
                  valid_q <= 1'b0;
                  rel_q   <= 1'b1;
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               mask_q  <= ALL_ONES;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (load_grant) begin
            gnt_q   <= pick;
            yadd_q  <= pick_idx;
            valid_q <= 1'b1;
            mask_q  <= mask_after;
            hold_q  <= '0;
`ifdef COL_ARB_SNAPSHOT_EN
            snap_q  <= cand & ~pick;
`endif
         end
      end
   end

   assign gnt_o         = gnt_q;
   assign gnt_valid_o   = valid_q;
   assign yadd_o        = yadd_q;
   assign grp_release_o = rel_q;
   assign timeout_o     = to_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_column_pass_arbiter.sv
// tb/tb_column_pass_arbiter.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_column_pass_arbiter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       ack;
   logic [7:0] req;

   logic [7:0] g0, g4;
   logic       v0, v4, r0, r4, t0, t4, b0, b4;
   logic [2:0] y0, y4;

   int checks   = 0;
   int failures = 0;

   column_pass_arbiter #(.Lvl_COLS(8), .Lvl_COL_ADD(3), .HOLD_MAX(0)) dut0 (
      .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req), .ack_i(ack),
      .gnt_o(g0), .gnt_valid_o(v0), .yadd_o(y0), .grp_release_o(r0),
      .timeout_o(t0), .busy_o(b0)
   );

   column_pass_arbiter #(.Lvl_COLS(8), .Lvl_COL_ADD(3), .HOLD_MAX(4)) dut4 (
      .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req), .ack_i(ack),
      .gnt_o(g4), .gnt_valid_o(v4), .yadd_o(y4), .grp_release_o(r4),
      .timeout_o(t4), .busy_o(b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a pass is "serve the lowest requester above the last served column".
   localparam int HOLDS [2] = '{0, 4};
   bit         mv    [2];
   int         my    [2];
   bit         mrel  [2];
   bit         mto   [2];
   bit         mpass [2];
   int         mlast [2];
   int         mheld [2];
   logic [7:0] msnap [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest_above(input logic [7:0] v, input int after);
      for (int j = after + 1; j < 8; j++) if (v[j]) return j;
      return -1;
   endfunction

   task automatic model_grant(input int k, input int j);
      mv[k] = 1; my[k] = j; mlast[k] = j; mheld[k] = 1;
   endtask

   task automatic model_step(input int k);
      int         j;
      logic [7:0] src;
      bit         was_rel;
      if (rst || !en) begin
         mv[k] = 0; my[k] = 0; mrel[k] = 0; mto[k] = 0; mpass[k] = 0; mlast[k] = -1;
      end else begin
         was_rel = mrel[k];
         mrel[k] = 0;
         mto[k]  = 0;
`ifdef COL_ARB_SNAPSHOT_EN
         src = msnap[k];
`else
         src = req;
`endif
         if (was_rel) begin
            mpass[k] = 0; mlast[k] = -1;
         end else if (!mpass[k]) begin
            j = lowest_above(req, -1);
            if (j >= 0) begin
               model_grant(k, j); mpass[k] = 1; msnap[k] = req;
            end
         end else if (mv[k] && !ack) begin
            if (HOLDS[k] > 0 && mheld[k] == HOLDS[k]) begin
               mv[k] = 0; my[k] = 0; mto[k] = 1;
            end else begin
               mheld[k]++;
            end
         end else begin
            j = lowest_above(src, mlast[k]);
            if (j >= 0) model_grant(k, j);
            else begin
               mv[k] = 0; my[k] = 0; mrel[k] = 1;
            end
         end
      end
   endtask

   task automatic cmp_dut(input int k, input logic [7:0] g, input logic v, input logic [2:0] y,
                          input logic r, input logic t, input logic b);
      logic [7:0] eg;
      eg = mv[k] ? 8'(1 << my[k]) : 8'h00;
      check($sformatf("d%0d_gnt", k), g, eg);
      check($sformatf("d%0d_valid", k), v, mv[k]);
      check($sformatf("d%0d_yadd", k), y, my[k]);
      check($sformatf("d%0d_release", k), r, mrel[k]);
      check($sformatf("d%0d_timeout", k), t, mto[k]);
      check($sformatf("d%0d_busy", k), b, mpass[k]);
      check($sformatf("d%0d_onehot0", k), $onehot0(g), 1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) model_step(k);
      cmp_dut(0, g0, v0, y0, r0, t0, b0);
      cmp_dut(1, g4, v4, y4, r4, t4, b4);
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] req;
      logic       ack;
      logic [7:0] e_gnt;
      logic [2:0] e_yadd;
      logic       e_valid;
      logic       e_rel;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q, input logic a,
                               input logic [7:0] g, input logic [2:0] y, input logic v,
                               input logic rl, input logic bz);
      vec_t t;
      t.rst = r; t.en = e; t.req = q; t.ack = a;
      t.e_gnt = g; t.e_yadd = y; t.e_valid = v; t.e_rel = rl; t.e_busy = bz;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      rst = 1'b1; en = 1'b0; ack = 1'b0; req = 8'h00;

      // Expected outputs of the HOLD_MAX=0 instance after the edge that samples each row.
      tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h01, 0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 8'hA5, 1, 8'h04, 2, 1, 0, 1));
      tbl.push_back(mk(0, 1, 8'hA5, 1, 8'h20, 5, 1, 0, 1));
      tbl.push_back(mk(0, 1, 8'hA5, 1, 8'h80, 7, 1, 0, 1));
      tbl.push_back(mk(0, 1, 8'hA5, 1, 8'h00, 0, 0, 1, 1));
      tbl.push_back(mk(0, 1, 8'hA5, 1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h01, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 8'hA5, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h10, 0, 8'h10, 4, 1, 0, 1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h00, 0, 8'h10, 4, 1, 0, 1));
      tbl.push_back(mk(0, 1, 8'h00, 1, 8'h00, 0, 0, 1, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; en = tbl[i].en; req = tbl[i].req; ack = tbl[i].ack;
         tick();
         check($sformatf("tbl%0d_gnt", i), g0, tbl[i].e_gnt);
         check($sformatf("tbl%0d_yadd", i), y0, tbl[i].e_yadd);
         check($sformatf("tbl%0d_valid", i), v0, tbl[i].e_valid);
         check($sformatf("tbl%0d_release", i), r0, tbl[i].e_rel);
         check($sformatf("tbl%0d_busy", i), b0, tbl[i].e_busy);
      end

      // Reset held two cycles mid-pass, then the pass restarts at column 0.
      rst = 0; en = 1; req = 8'hA5; ack = 0;
      tick();
      ack = 1; tick();
      check("rst_pre_col2", y0, 2);
      rst = 1; ack = 0; tick();
      check("rst_valid", v0, 0); check("rst_gnt", g0, 0); check("rst_busy", b0, 0);
      tick();
      rst = 0; tick();
      check("rst_restart_col0", y0, 0); check("rst_restart_valid", v0, 1);

      // Abort while column 2 is granted; re-enable serves column 2 first.
      ack = 1; tick();
      check("abort_pre_col2", y0, 2);
      en = 0; ack = 0; tick();
      check("abort_gnt", g0, 0); check("abort_release", r0, 0); check("abort_busy", b0, 0);
      en = 1; req = 8'h0C; tick();
      check("reenable_col2", y0, 2); check("reenable_gnt", g0, 8'h04);
      en = 0; tick();

      // Live order: bits raised after column 2 is served.
      en = 1; req = 8'h05; ack = 0; tick();
      check("live_col0", y0, 0);
      ack = 1; tick();
      check("live_col2", y0, 2);
      req = 8'h47; tick();
`ifdef COL_ARB_SNAPSHOT_EN
      check("snap_defer_col6", v0, 0); check("snap_release", r0, 1);
`else
      check("live_col6", y0, 6); check("live_col6_valid", v0, 1);
      tick();
      check("live_release", r0, 1); check("live_release_valid", v0, 0);
`endif
      ack = 0; tick();
      check("pass2_idle", v0, 0);
      tick();
      check("pass2_col0", y0, 0);
      ack = 1; tick();
      check("pass2_col1", y0, 1);
      en = 0; ack = 0; tick();

      // Hold timeout on the HOLD_MAX=4 instance, then ack coincident with expiry.
      en = 1; req = 8'h03; ack = 0; tick();
      check("to_col0", y4, 0); check("to_col0_valid", v4, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_col0_hold", v4, 1); check("to_col0_nopulse", t4, 0);
      end
      tick();
      check("to_pulse", t4, 1); check("to_cleared", v4, 0); check("to_gnt_zero", g4, 0);
      tick();
      check("to_next_col1", y4, 1); check("to_next_valid", v4, 1); check("to_pulse_gone", t4, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_col1_hold", v4, 1);
      end
      ack = 1; tick();
      check("ack_wins_no_timeout", t4, 0); check("ack_wins_release", r4, 1);
      en = 0; ack = 0; tick();

      // Randomised traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 5) == 0) req = 8'($urandom & $urandom);
         ack = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 9) == 0) ack = 1'b0;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/column_pass_arbiter.md
Name: column_pass_arbiter

Overview:
Parametrised successor to the column arbiter. Grants the active columns of the selected row one at a time, in ascending index order, one pass per row scan. Each grant is held under a valid/ack handshake, with an optional hold timeout. A single-cycle group-release pulse marks pass completion. Sits between the row arbiter and the event readout logic.

Parameters:
Lvl_COLS, 8, number of column request lines (>=2)
Lvl_COL_ADD, 3, width of encoded column address; must be >= $clog2(Lvl_COLS) (elaboration assertion)
HOLD_MAX, 0, max cycles a grant waits for ack; 0 disables timeout

Ports:
clk_i  input  1  clock; all logic on rising edge
reset_i  input  1  synchronous, active-high reset
enable_i  input  1  row selected; low aborts pass
req_i  input  Lvl_COLS  column requests (level)
ack_i  input  1  downstream accepted current grant
gnt_o  output  Lvl_COLS  registered one-hot grant
gnt_valid_o  output  1  gnt_o/yadd_o valid
yadd_o  output  Lvl_COL_ADD  registered binary index of gnt_o
grp_release_o  output  1  one-cycle pulse: pass complete
timeout_o  output  1  one-cycle pulse: grant dropped by timeout
busy_o  output  1  state != IDLE

Behaviour:
- Reset (sync): all outputs 0; mask_ff = all ones; hold counter 0; state IDLE.
- Internal: mask_req = req_i & mask_ff. Next grant = lowest set bit of mask_req (Priority_arb). Granting index i sets mask_ff = ones << (i+1).
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if enable_i && |mask_req -> register grant, gnt_valid_o=1 -> GRANT.
  - GRANT: gnt_o/yadd_o frozen until ack_i or timeout. Sticky: withdrawing the req bit does not drop the grant.
  - On ack_i: if the masked requests above the granted column are non-zero, register the next grant on the same edge (back-to-back, no bubble). Otherwise clear outputs -> RELEASE.
  - RELEASE: grp_release_o=1 for exactly one cycle; mask_ff = all ones; -> IDLE.
- Latency: request seen in IDLE at edge N -> gnt_valid_o at N+1. Final ack at N -> release pulse at N+1 -> earliest new grant at N+2.
- Empty pass: enable_i high, req_i=0 -> remain IDLE, no release pulse.
- Live mode: a request newly raised above the last grant is served in the current pass. A request raised at or below the last grant waits for the next pass.
- Timeout (HOLD_MAX>0): counter starts at 0 on each new grant. When it reaches HOLD_MAX without ack, clear gnt_o/gnt_valid_o and pulse timeout_o. The mask stays advanced past that column, and the FSM continues as if acked (next grant or RELEASE on the following edge). Ack arriving in the same cycle as expiry wins: no timeout.
- enable_i low in any state: next edge clears gnt_o/gnt_valid_o/yadd_o, resets mask to all ones and goes to IDLE. No grp_release_o, no timeout_o. Re-enable restarts from column 0.
- ack_i ignored when gnt_valid_o=0.
- Reset has priority over all events.
- Invariant: gnt_o is one-hot or zero; yadd_o=0 whenever gnt_valid_o=0.

Optional Feature:
COL_ARB_SNAPSHOT_EN
- Defined: req_i is captured into a snapshot register on the IDLE->GRANT edge. The whole pass serves only snapshot bits (mask_req = snapshot & mask_ff). Requests arriving mid-pass wait for the next pass. Snapshot bits clear as each column is granted.
- Undefined: live mode as above; no snapshot register.

Decomposition:
- lib_arbiter_pkg:
  - typedef enum logic [1:0] col_arb_state_t {IDLE, GRANT, RELEASE}
  - function onehot_to_bin (parametrised by width)
  - shared default constants for Lvl_COLS/HOLD_MAX
- Sub-module: reuse existing Priority_arb (Lvl_ROWS=Lvl_COLS) for lowest-index selection.
- Hold counter and FSM stay in column_pass_arbiter.

Test Plan:
- Reset: assert reset_i 2 cycles mid-pass -> all outputs 0 next edge; busy_o=0; next pass starts at column 0.
- Lvl_COLS=8, req_i=8'b1010_0101 held, ack_i=1 every valid cycle -> yadd_o 0,2,5,7 on 4 consecutive cycles; grp_release_o pulses the cycle after ack of 7; yadd_o=0 again 2 cycles after last ack.
- Live order: req_i=8'h05; after grant of col 2, raise bit 6 and bit 1 -> col 6 granted this pass; col 1 only after the release pulse. With COL_ARB_SNAPSHOT_EN, col 6 is also deferred to the next pass.
- Stall: req_i=8'h10, ack_i low 5 cycles, req withdrawn at cycle 2 -> gnt_o=8'h10, yadd_o=4 stable all 5 cycles; ack -> release pulse next cycle.
- Timeout: HOLD_MAX=4, req_i=8'h03, no ack -> col 0 valid 4 cycles, timeout_o pulse, col 1 granted next edge. Ack coincident with expiry -> no timeout_o.
- Abort: enable_i low while col 2 is granted -> outputs 0 next edge, no grp_release_o; re-enable with req_i=8'h0C -> grant col 2 first.
